// File: rtl/uart_defs_pkg.sv
// uart_defs: shared constants for the UART receive monitor.
//   - parity mode encodings (NONE/ODD/EVEN)
//   - oversampling ratio and the mid-bit sample index
//   - receive FSM state encoding
//   - expected parity helper
package uart_defs;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    localparam int          OVERSAMPLE = 16;
    localparam logic [3:0]  MID_SAMPLE = 4'd7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    // Parity bit a correct transmitter sends for this byte.
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        return (mode == PARITY_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: first-word fall-through byte FIFO.
//   clk, rst_n : clock, synchronous active-low reset (empties the FIFO)
//   wr_en, din : push request and data; accepted when not full, or when
//                full together with an effective pop
//   rd_en      : pop request; ignored while empty
//   dout       : head entry, forced to 8'h00 while empty
//   empty,full : derived from the extended-pointer compare
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [7:0] din,
    input  logic       rd_en,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [7:0]  mem [DEPTH];
    logic        do_rd;
    logic        do_wr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd = rd_en && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_tx_monitor.sv
// uart_tx_monitor: UART receiver watching the CPU serial Tx line.
// Decodes 8-bit LSB-first frames with optional parity, buffers good bytes
// in a FWFT FIFO and keeps sticky error flags.
//   clk, rst_n      : clock, synchronous active-low reset
//   rx              : asynchronous serial input, idles high
//   rd_en           : pop FIFO head
//   dout/empty/full : FIFO head and status
//   parity_err      : sticky, a frame failed the parity check
//   frame_err       : sticky, a stop bit was sampled low
//   overflow        : sticky, a good byte was lost to a full FIFO
//   clr_err         : clears the sticky flags (a same-cycle new error wins)
//
// state   | meaning
// IDLE    | line idle, waiting for a synchronized falling edge
// START   | confirming the start bit at mid-bit (high = glitch)
// DATA    | sampling 8 data bits LSB first
// PARITY  | sampling and checking the parity bit
// STOP    | sampling the stop bit, then push or flag; back to IDLE at mid-bit
module uart_tx_monitor
    import uart_defs::*;
#(
    parameter int SYS_CLK_FREQ = 100000000,
    parameter int BAUD_RATE    = 115200,
    parameter int PARITY_MODE  = 2,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       rd_en,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overflow,
    input  logic       clr_err
);

    localparam int DIV_RAW = SYS_CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    logic          rx_meta;
    logic          rx_sync;
    logic          rx_prev;
    logic [DW-1:0] div_cnt;
    logic          tick;
    logic [3:0]    sample_cnt;
    logic          mid;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          par_bad;

    rx_state_t     state;
    rx_state_t     state_nxt;
    logic          cnt_clr;
    logic          shift_en;
    logic          par_chk;
    logic          push;
    logic          fe_set;
    logic          pe_set;
    logic          ov_set;

    // Synchronizer and edge-detect history reset high so reset release
    // never looks like a start edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Free-running 16x oversample tick.
    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) div_cnt <= '0;
        else        div_cnt <= tick ? '0 : div_cnt + 1'b1;
    end

    assign mid = tick && (sample_cnt == MID_SAMPLE);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        par_chk   = 1'b0;
        push      = 1'b0;
        fe_set    = 1'b0;
        pe_set    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (rx_prev && !rx_sync) begin
                    cnt_clr   = 1'b1;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (mid) state_nxt = rx_sync ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (mid) begin
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7)
                        state_nxt = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (mid) begin
                    par_chk   = 1'b1;
                    state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                // Leaving at mid-stop leaves half a bit to catch the next start edge.
                if (mid) begin
                    state_nxt = ST_IDLE;
                    if (!rx_sync)     fe_set = 1'b1;
                    else if (par_bad) pe_set = 1'b1;
                    else              push   = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sample_cnt <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            par_bad    <= 1'b0;
        end else begin
            if (cnt_clr)   sample_cnt <= '0;
            else if (tick) sample_cnt <= sample_cnt + 4'd1;

            if (cnt_clr)       bit_idx <= '0;
            else if (shift_en) bit_idx <= bit_idx + 3'd1;

            if (shift_en) shreg <= {rx_sync, shreg[7:1]};

            if (cnt_clr)      par_bad <= 1'b0;
            else if (par_chk) par_bad <= (rx_sync != parity_bit(shreg, PARITY_MODE));
        end
    end

    // When full the FIFO cannot be empty, so rd_en always frees a slot.
    assign ov_set = push && full && !rd_en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            parity_err <= pe_set || (parity_err && !clr_err);
            frame_err  <= fe_set || (frame_err  && !clr_err);
            overflow   <= ov_set || (overflow   && !clr_err);
        end
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (push),
        .din   (shreg),
        .rd_en (rd_en),
        .dout  (dout),
        .empty (empty),
        .full  (full)
    );

endmodule

// File: tb/tb_uart_tx_monitor.sv
// Bench for uart_tx_monitor: frames are serialized from a byte-level model,
// expected bytes go into a queue, and a monitor drains the FIFO and compares.
module tb_uart_tx_monitor;

    localparam int BIT_CLKS = 160;
    localparam int DEPTH    = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rd_en = 1'b0;
    logic       clr_err = 1'b0;
    logic [7:0] dout;
    logic       empty;
    logic       full;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;

    always #5 clk = ~clk;

    uart_tx_monitor #(
        .SYS_CLK_FREQ (1600000),
        .BAUD_RATE    (10000),
        .PARITY_MODE  (2),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rd_en      (rd_en),
        .dout       (dout),
        .empty      (empty),
        .full       (full),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .clr_err    (clr_err)
    );

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    bit         auto_rd = 1'b0;
    bit         exp_pe = 1'b0;
    bit         exp_fe = 1'b0;
    bit         exp_ov = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops whenever the DUT presents a byte and reading is enabled.
    initial begin
        forever begin
            @(negedge clk);
            if (auto_rd && rst_n && !empty) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_byte: got %0h, expected no byte", dout);
                end else begin
                    check("rx_byte", {24'h0, dout}, {24'h0, exp_q.pop_front()});
                end
                rd_en = 1'b1;
            end else begin
                rd_en = 1'b0;
            end
        end
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(posedge clk);
    endtask

    // Model a frame at byte level, then serialize it.
    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        if (bad_stop)                                 exp_fe = 1'b1;
        else if (bad_par)                             exp_pe = 1'b1;
        else if (!auto_rd && exp_q.size() >= DEPTH)   exp_ov = 1'b1;
        else                                          exp_q.push_back(d);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit((^d) ^ bad_par);
        drive_bit(!bad_stop);
        rx = 1'b1;
        if (bad_stop) repeat (20) @(posedge clk);
    endtask

    task automatic check_flags(input string tag);
        @(negedge clk);
        check({tag, "_parity_err"}, {31'h0, parity_err}, {31'h0, exp_pe});
        check({tag, "_frame_err"},  {31'h0, frame_err},  {31'h0, exp_fe});
        check({tag, "_overflow"},   {31'h0, overflow},   {31'h0, exp_ov});
    endtask

    task automatic clear_flags();
        @(negedge clk);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        exp_pe = 1'b0;
        exp_fe = 1'b0;
        exp_ov = 1'b0;
    endtask

    task automatic drain(input string tag);
        int budget;
        budget = 400;
        auto_rd = 1'b1;
        while ((exp_q.size() != 0 || !empty) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check({tag, "_drain_left"}, exp_q.size(), 0);
        @(negedge clk);
        @(negedge clk);
        check({tag, "_empty"}, {31'h0, empty}, 32'h1);
    endtask

    task automatic check_reset_vals(input string tag);
        @(negedge clk);
        check({tag, "_empty"}, {31'h0, empty}, 32'h1);
        check({tag, "_full"},  {31'h0, full},  32'h0);
        check({tag, "_dout"},  {24'h0, dout},  32'h0);
        check({tag, "_pe"},    {31'h0, parity_err}, 32'h0);
        check({tag, "_fe"},    {31'h0, frame_err},  32'h0);
        check({tag, "_ov"},    {31'h0, overflow},   32'h0);
    endtask

    initial begin
        logic [7:0] d7e;
        logic [7:0] rd;
        bit         bp;
        bit         bs;

        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        repeat (10) @(posedge clk);

        // Good even-parity byte, held in the FIFO.
        auto_rd = 1'b0;
        send_frame(8'h41, 1'b0, 1'b0);
        @(negedge clk);
        check("good41_empty", {31'h0, empty}, 32'h0);
        check("good41_dout", {24'h0, dout}, 32'h41);
        check_flags("good41");
        drain("good41");

        // Forced parity error.
        send_frame(8'h41, 1'b1, 1'b0);
        check_flags("par41");
        check("par41_empty", {31'h0, empty}, 32'h1);
        clear_flags();
        check_flags("par41_clr");

        // Frame error, then a clean frame.
        send_frame(8'h55, 1'b0, 1'b1);
        check_flags("stop55");
        check("stop55_empty", {31'h0, empty}, 32'h1);
        clear_flags();
        send_frame(8'h0A, 1'b0, 1'b0);
        drain("next0a");
        check_flags("next0a");

        // Short low glitch on the idle line.
        rx = 1'b0;
        repeat (40) @(posedge clk);
        rx = 1'b1;
        repeat (300) @(posedge clk);
        check_flags("glitch");
        check("glitch_empty", {31'h0, empty}, 32'h1);

        // Fill past capacity with no reads.
        auto_rd = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            send_frame(8'(k), 1'b0, 1'b0);
            @(negedge clk);
            check($sformatf("fill%0d_full", k), {31'h0, full}, {31'h0, exp_q.size() == DEPTH});
            check_flags($sformatf("fill%0d", k));
        end
        drain("fill");
        clear_flags();
        check_flags("fill_clr");

        // Reset in the middle of DATA with a byte already buffered.
        auto_rd = 1'b0;
        send_frame(8'h99, 1'b0, 1'b0);
        @(negedge clk);
        check("pre_rst_empty", {31'h0, empty}, 32'h0);
        d7e = 8'h7E;
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(d7e[i]);
        rx = d7e[3];
        repeat (BIT_CLKS / 2) @(posedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        exp_pe = 1'b0;
        exp_fe = 1'b0;
        exp_ov = 1'b0;
        repeat (3) @(posedge clk);
        check_reset_vals("midrst");
        rx = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        auto_rd = 1'b1;
        send_frame(8'h31, 1'b0, 1'b0);
        drain("after_rst");
        check_flags("after_rst");

        // Randomized frames with occasional errors and short gaps.
        auto_rd = 1'b1;
        for (int n = 0; n < 12; n++) begin
            rd = 8'($urandom);
            bp = ($urandom_range(0, 5) == 0);
            bs = ($urandom_range(0, 6) == 0);
            send_frame(rd, bp, bs);
            check_flags($sformatf("rand%0d", n));
            if (exp_pe || exp_fe || exp_ov) clear_flags();
            repeat ($urandom_range(0, 30)) @(posedge clk);
        end
        drain("rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
